// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/SRA/ROL unit shifting at most STEP bits per clock
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     abort,
    output logic                     busy
);
    localparam int SW = $clog2(WIDTH);
    // STEP may equal WIDTH, so it needs one bit more than a shift amount
    localparam logic [SW:0] STEP_W  = (SW+1)'(STEP);
    localparam logic [SW:0] WIDTH_W = (SW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  step_res;
    logic [SW-1:0]     rem_q;
    logic [SW-1:0]     rem_next;
    logic [SW-1:0]     s;
    logic [SW:0]       rot_back;
    logic [1:0]        op_q;
    logic              accept;

    assign in_ready  = (state == IDLE) && !abort;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // One partial step: shift by min(rem, STEP); rem < WIDTH so the STEP branch
    // is only taken when STEP itself fits in a shift amount.
    always_comb begin
        s        = ({1'b0, rem_q} > STEP_W) ? STEP_W[SW-1:0] : rem_q;
        rem_next = rem_q - s;
        rot_back = WIDTH_W - {1'b0, s};
        step_res = data_q;
        case (op_q)
            2'b00:   step_res = data_q << s;
            2'b01:   step_res = data_q >> s;
            // data_q[WIDTH-1] always equals the latched operand's sign under SRA
            2'b10:   step_res = $unsigned($signed(data_q) >>> s);
            default: step_res = (data_q << s) | (data_q >> rot_back);
        endcase
    end

    // Next-state logic; abort overrides everything and returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (in_shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_next == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture, stepwise shifting and result capture on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            rem_q    <= '0;
            op_q     <= '0;
            out_data <= '0;
        end else if (accept) begin
            data_q <= in_data;
            op_q   <= in_op;
            rem_q  <= in_shamt;
            if (in_shamt == '0) out_data <= in_data;
        end else if (state == SHIFT && !abort) begin
            data_q <= step_res;
            rem_q  <= rem_next;
            if (rem_next == '0) out_data <= step_res;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - table-driven bench for shift_sequencer with STEP=4, 1 and 32
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic        out_ready = 1'b0;
    logic        abort = 1'b0;

    logic        ir4, ov4, bz4, ir1, ov1, bz1, ir32, ov32, bz32;
    logic [31:0] od4, od1, od32;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .abort(abort), .busy(bz4)
    );
    shift_sequencer #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .abort(abort), .busy(bz1)
    );
    shift_sequencer #(.WIDTH(32), .STEP(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32),
        .abort(abort), .busy(bz32)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            2'd0:    r = d << sh;
            2'd1:    r = d >> sh;
            2'd2:    r = $signed(d) >>> sh;
            default: r = (sh == 0) ? d : ((d << sh) | (d >> (32 - int'(sh))));
        endcase
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!(ir4 && ir1 && ir32) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_wait", {31'd0, ir4 && ir1 && ir32}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        wait_idle();
        in_op = op; in_data = d; in_shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = ~d; in_shamt = ~sh; in_op = ~op;
    endtask

    task automatic wait_all_valid();
        int n = 0;
        while (!(ov4 && ov1 && ov32) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("valid_wait", {31'd0, ov4 && ov1 && ov32}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [31:0] exp, input int lat);
        int n = 0;
        issue(op, d, sh);
        while (!ov4 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"}, n, lat);
        wait_all_valid();
        chk({tag, "_s4"}, od4, exp);
        chk({tag, "_s1"}, od1, exp);
        chk({tag, "_s32"}, od32, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_vdrop"}, {31'd0, ov4}, 32'd0);
        chk({tag, "_ready"}, {31'd0, ir4}, 32'd1);
    endtask

    initial begin
        logic        ov_seen;
        logic [1:0]  rop;
        logic [31:0] rd;
        logic [4:0]  rsh;

        vecs[0]  = '{2'd0, 32'h00000001, 5'd2,  32'h00000004, 1};
        vecs[1]  = '{2'd2, 32'h80000000, 5'd31, 32'hFFFFFFFF, 8};
        vecs[2]  = '{2'd1, 32'h80000000, 5'd31, 32'h00000001, 8};
        vecs[3]  = '{2'd3, 32'h80000001, 5'd4,  32'h00000018, 1};
        vecs[4]  = '{2'd0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0};
        vecs[5]  = '{2'd2, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0};
        vecs[6]  = '{2'd3, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0};
        vecs[7]  = '{2'd0, 32'h0000FFFF, 5'd2,  32'h0003FFFC, 1};
        vecs[8]  = '{2'd2, 32'hF0000000, 5'd4,  32'hFF000000, 1};
        vecs[9]  = '{2'd1, 32'hF0000000, 5'd4,  32'h0F000000, 1};
        vecs[10] = '{2'd3, 32'h12345678, 5'd8,  32'h34567812, 2};
        vecs[11] = '{2'd2, 32'h7FFFFFFF, 5'd31, 32'h00000000, 8};
        vecs[12] = '{2'd0, 32'hFFFFFFFF, 5'd31, 32'h80000000, 8};
        vecs[13] = '{2'd1, 32'hDEADBEEF, 5'd5,  32'h06F56DF7, 2};
        vecs[14] = '{2'd3, 32'h80000000, 5'd1,  32'h00000001, 1};
        vecs[15] = '{2'd3, 32'h00000001, 5'd31, 32'h80000000, 8};

        // reset state
        #12;
        chk("rst_valid", {31'd0, ov4}, 32'd0);
        chk("rst_busy", {31'd0, bz4}, 32'd0);
        chk("rst_data", od4, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, ir4}, 32'd1);

        // directed table
        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp, vecs[i].lat);

        // backpressure: result and flags held while out_ready is low
        issue(2'd0, 32'h0000FFFF, 5'd2);
        wait_all_valid();
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", od4, 32'h0003FFFC);
            chk("bp_valid", {31'd0, ov4}, 32'd1);
            chk("bp_in_ready", {31'd0, ir4}, 32'd0);
            chk("bp_busy", {31'd0, bz4}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_busy", {31'd0, bz4}, 32'd0);

        // abort in the third SHIFT cycle of a 31-bit shift
        issue(2'd1, 32'h80000000, 5'd31);
        ov_seen = ov4;
        @(posedge clk); #1;
        ov_seen |= ov4;
        @(posedge clk); #1;
        ov_seen |= ov4;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy4", {31'd0, bz4}, 32'd0);
        chk("abort_busy1", {31'd0, bz1}, 32'd0);
        chk("abort_busy32", {31'd0, bz32}, 32'd0);
        chk("abort_valid", {31'd0, ov4}, 32'd0);
        @(posedge clk); #1;
        ov_seen |= ov4;
        chk("abort_never_valid", {31'd0, ov_seen}, 32'd0);
        abort = 1'b1;
        #1;
        chk("abort_idle_blocks", {31'd0, ir4}, 32'd0);
        abort = 1'b0;
        #1;
        run_op("post_abort", 2'd0, 32'h00000003, 5'd2, 32'h0000000C, 1);

        // asynchronous reset between edges in the middle of SHIFT
        issue(2'd2, 32'h80000000, 5'd31);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid4", {31'd0, ov4}, 32'd0);
        chk("arst_data4", od4, 32'd0);
        chk("arst_busy4", {31'd0, bz4}, 32'd0);
        chk("arst_data1", od1, 32'd0);
        chk("arst_valid32", {31'd0, ov32}, 32'd0);
        chk("arst_data32", od32, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_in_ready", {31'd0, ir4}, 32'd1);

        // random operations against the reference model on all three step sizes
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            rd  = $urandom;
            rsh = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d", i), rop, rd, rsh, ref_op(rop, rd, rsh), (int'(rsh) + 3) / 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the CPU execute stage.
- Performs SLL/SRL/SRA/ROL by a runtime amount (0..WIDTH-1), shifting at most STEP bits per clock.
- Exchanges requests and results with the pipeline control over a valid/ready handshake on each side.
- Replaces a wide single-cycle barrel shifter where area or timing matters.

Parameters:
- WIDTH, 32: data width. Must be a power of two, >= 2.
- STEP, 4: maximum bits shifted per cycle. Must be a power of two, 1..WIDTH.
- Shift-amount width is SW = $clog2(WIDTH). This is a localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request can be accepted this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SW  shift amount
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- abort  in  1  synchronous flush of any in-flight operation
- busy  out  1  state != IDLE

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE, out_valid = 0, out_data = 0, busy = 0.
  - Internal data, remaining-count and op registers = 0.
  - in_ready = 1 once reset deasserts, provided abort = 0.
- States are IDLE, SHIFT, DONE.
- in_ready = (state == IDLE) && !abort. It is combinational. A request is accepted on a rising edge with in_valid && in_ready.
- On accept:
  - Latch in_data, in_op, and rem = in_shamt.
  - If in_shamt == 0: next state is DONE, data unchanged.
  - Otherwise: next state is SHIFT.
- SHIFT, on each edge:
  - s = min(rem, STEP). Apply op by s bits to the data register; rem <= rem - s.
  - If rem - s == 0, next state is DONE; otherwise stay in SHIFT.
  - SLL/SRL fill with zeros.
  - SRA fills with bit WIDTH-1 of the latched operand. Sign is preserved across steps.
  - ROL rotates left; bits leaving the MSB enter the LSB.
- DONE:
  - out_valid = 1 and out_data = data register.
  - Both are held stable while out_ready = 0.
  - An edge with out_ready = 1 completes the transfer: next state is IDLE and out_valid drops.
- Latency: out_valid is first high ceil(shamt/STEP) cycles after the cycle following the accept edge.
  - shamt = 0: out_valid high in the cycle directly after accept.
  - With STEP = 4, shamt = 31 takes 8 SHIFT cycles.
- Throughput: one operation at a time. No accept in the same cycle as result hand-off. The next request is accepted no earlier than one cycle after DONE -> IDLE.
- out_data in IDLE/SHIFT: holds its last value. Consumers qualify with out_valid only.
- Inputs in_data, in_shamt and in_op are ignored unless accepted. Changing them during SHIFT has no effect.
- abort, synchronous, highest priority:
  - In SHIFT or DONE: next state is IDLE, result is discarded, out_valid is 0 next cycle.
  - In IDLE: blocks acceptance via in_ready.
  - abort together with out_ready in DONE: state goes to IDLE. Consumer behaviour in that cycle is undefined; control must not rely on it.
- Reset mid-operation: immediate, asynchronous return to reset values. No result is produced.
- Arithmetic: the result always equals the single-step reference op(in_data, in_shamt) truncated to WIDTH. Shifts never overflow into a wider register.

Test Plan (WIDTH=32, STEP=4 unless noted):
- SLL 0x00000001 by 2, out_ready=1 -> out_data 0x00000004, out_valid high exactly 1 SHIFT cycle after accept, in_ready high the cycle after hand-off.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF after 8 SHIFT cycles. SRL of the same operand and amount -> 0x00000001.
- ROL 0x80000001 by 4 -> 0x00000018. Shamt 0 with any op on 0xDEADBEEF -> 0xDEADBEEF, out_valid in the first cycle after accept.
- Backpressure: SLL 0x0000FFFF by 2, hold out_ready=0 for 5 cycles -> out_data 0x0003FFFC stable, out_valid=1, in_ready=0, busy=1 throughout. Release -> IDLE next edge.
- Abort in the 3rd SHIFT cycle of a 31-bit shift -> out_valid never asserts, busy=0 next cycle. A new request of 0x00000003 SLL 2 -> 0x0000000C.
- rst_n pulsed low mid-SHIFT (asynchronous, between edges) -> out_valid=0, out_data=0, busy=0 immediately. Repeat the random-op comparison against the reference model with STEP=1 and STEP=32.
